jtlabrun_romarb: RTL and testbench

Arbiter sharing one SDRAM ROM read slot between the main 6809 program-ROM fetch (bank-switched, 3 MHz CPU) and a graphics ROM requester.
- Sits between the main CPU board and the SDRAM controller.
- Tracks per-requester last-fetched address and data, so repeated reads of the same address return without a new SDRAM access.
- Fixed CPU priority with a starvation guard for the gfx side.

---
 rtl/jtlabrun_romarb_pkg.sv | 5 +
 rtl/jtlabrun_romarb_slot.sv | 36 +++
 rtl/jtlabrun_romarb.sv | 106 ++++++++++
 tb/tb_jtlabrun_romarb.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/jtlabrun_romarb_pkg.sv
// jtlabrun_romarb_pkg: shared FSM state and grant encodings for the ROM arbiter.
package jtlabrun_romarb_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT_ACK, ST_WAIT_DATA} state_e;
    typedef enum logic {GNT_CPU, GNT_GFX} gnt_e;
endpackage

// File: rtl/jtlabrun_romarb_slot.sv
// jtlabrun_romarb_slot: one-entry cache per requester; ok is a live compare against the current address.
module jtlabrun_romarb_slot #(
    parameter int AW = 17,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    input  logic          wr,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic [DW-1:0] data,
    output logic          ok,
    output logic          pending
);
    logic [AW-1:0] last_q;
    logic [DW-1:0] data_q;
    logic          valid_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (wr) begin
            last_q  <= wr_addr;
            data_q  <= wr_data;
            valid_q <= 1'b1;
        end
    end

    assign data    = data_q;
    assign ok      = cs & valid_q & (addr == last_q);
    assign pending = cs & ~ok;
endmodule

// File: rtl/jtlabrun_romarb.sv
// jtlabrun_romarb: shares one SDRAM read slot between CPU and gfx ROM fetches, CPU first with a gfx starvation guard.
// Optional abort of stalled SDRAM transactions with JTLABRUN_ROMARB_TIMEOUT_EN.
module jtlabrun_romarb
    import jtlabrun_romarb_pkg::*;
#(
    parameter int AW      = 17,
    parameter int DW      = 8,
    parameter int STARVE  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          cpu_cs,
    input  logic [AW-1:0] cpu_addr,
    output logic [DW-1:0] cpu_data,
    output logic          cpu_ok,
    input  logic          gfx_cs,
    input  logic [AW-1:0] gfx_addr,
    output logic [DW-1:0] gfx_data,
    output logic          gfx_ok,
    output logic          sdram_req,
    output logic [AW-1:0] sdram_addr,
    input  logic          sdram_ack,
    input  logic          sdram_dok,
    input  logic [DW-1:0] sdram_data
);
    localparam int SW = $clog2(STARVE + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE);

    state_e        st_q;
    gnt_e          gnt_q;
    logic          req_q;
    logic [AW-1:0] addr_q;
    logic [SW-1:0] starve_q;
    logic          cpu_pend, gfx_pend, gfx_win, wr;

    // dok together with ack in WAIT_ACK counts as ack followed by data
    assign wr      = sdram_dok & (st_q == ST_WAIT_DATA | (st_q == ST_WAIT_ACK & sdram_ack));
    assign gfx_win = gfx_pend & (~cpu_pend | starve_q == STARVE_MAX);

`ifdef JTLABRUN_ROMARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT - 1);
    logic [TW-1:0] tmo_q;
    logic [SW-1:0] starve_bak_q;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st_q     <= ST_IDLE;
            gnt_q    <= GNT_CPU;
            req_q    <= 1'b0;
            addr_q   <= '0;
            starve_q <= '0;
`ifdef JTLABRUN_ROMARB_TIMEOUT_EN
            tmo_q        <= '0;
            starve_bak_q <= '0;
`endif
        end else begin
            case (st_q)
                ST_IDLE: if (cpu_pend | gfx_pend) begin
                    gnt_q    <= gfx_win ? GNT_GFX : GNT_CPU;
                    addr_q   <= gfx_win ? gfx_addr : cpu_addr;
                    req_q    <= 1'b1;
                    st_q     <= ST_WAIT_ACK;
                    starve_q <= gfx_win ? '0 :
                                (gfx_pend && starve_q != STARVE_MAX) ? starve_q + 1'b1 : starve_q;
`ifdef JTLABRUN_ROMARB_TIMEOUT_EN
                    starve_bak_q <= starve_q;
`endif
                end
                ST_WAIT_ACK: if (sdram_ack) begin
                    req_q <= 1'b0;
                    st_q  <= sdram_dok ? ST_IDLE : ST_WAIT_DATA;
                end
                ST_WAIT_DATA: if (sdram_dok) st_q <= ST_IDLE;
                default: st_q <= ST_IDLE;
            endcase
`ifdef JTLABRUN_ROMARB_TIMEOUT_EN
            tmo_q <= (st_q == ST_IDLE) ? '0 : tmo_q + 1'b1;
            // an aborted grant must leave the starvation count as if it never happened
            if (st_q != ST_IDLE && !wr && tmo_q == TMO_MAX) begin
                req_q    <= 1'b0;
                st_q     <= ST_IDLE;
                tmo_q    <= '0;
                starve_q <= starve_bak_q;
            end
`endif
        end
    end

    assign sdram_req  = req_q;
    assign sdram_addr = addr_q;

    jtlabrun_romarb_slot #(.AW(AW), .DW(DW)) u_cpu (
        .clk(clk), .rstn(rstn), .cs(cpu_cs), .addr(cpu_addr),
        .wr(wr & (gnt_q == GNT_CPU)), .wr_addr(addr_q), .wr_data(sdram_data),
        .data(cpu_data), .ok(cpu_ok), .pending(cpu_pend)
    );

    jtlabrun_romarb_slot #(.AW(AW), .DW(DW)) u_gfx (
        .clk(clk), .rstn(rstn), .cs(gfx_cs), .addr(gfx_addr),
        .wr(wr & (gnt_q == GNT_GFX)), .wr_addr(addr_q), .wr_data(sdram_data),
        .data(gfx_data), .ok(gfx_ok), .pending(gfx_pend)
    );
endmodule

// File: tb/tb_jtlabrun_romarb.sv
// tb_jtlabrun_romarb: directed bench with an SDRAM responder checking issued addresses against a queue of expected requests.
module tb_jtlabrun_romarb;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cpu_cs = 1'b0, gfx_cs = 1'b0;
    logic [16:0] cpu_addr = '0, gfx_addr = '0;
    logic [7:0]  cpu_data, gfx_data, sdram_data = '0;
    logic        cpu_ok, gfx_ok, sdram_req;
    logic [16:0] sdram_addr;
    logic        sdram_ack = 1'b0, sdram_dok = 1'b0;
    logic [16:0] exp_q[$];
    int          vectors = 0, errors = 0;

    jtlabrun_romarb dut (
        .clk(clk), .rstn(rstn),
        .cpu_cs(cpu_cs), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_ok(cpu_ok),
        .gfx_cs(gfx_cs), .gfx_addr(gfx_addr), .gfx_data(gfx_data), .gfx_ok(gfx_ok),
        .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
        .sdram_dok(sdram_dok), .sdram_data(sdram_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_req();
        int n = 0;
        while (!sdram_req && n < 40) begin
            tick();
            n++;
        end
        chk("req_seen", {31'd0, sdram_req}, 1);
    endtask

    // dok_dly == 0 returns data in the same cycle as ack
    task automatic serve(input logic [7:0] d, input int ack_dly, input int dok_dly,
                         input logic chg, input logic [16:0] chg_addr);
        logic [16:0] exp;
        wait_req();
        exp = exp_q.size() > 0 ? exp_q.pop_front() : 17'h1FFFF;
        chk("sdram_addr", {15'd0, sdram_addr}, {15'd0, exp});
        repeat (ack_dly) tick();
        chk("req_hold", {31'd0, sdram_req}, 1);
        chk("addr_hold", {15'd0, sdram_addr}, {15'd0, exp});
        sdram_ack = 1'b1;
        if (dok_dly == 0) begin
            sdram_dok  = 1'b1;
            sdram_data = d;
        end
        tick();
        sdram_ack = 1'b0;
        sdram_dok = 1'b0;
        chk("req_drop", {31'd0, sdram_req}, 0);
        if (dok_dly > 0) begin
            if (chg) cpu_addr = chg_addr;
            repeat (dok_dly - 1) tick();
            sdram_dok  = 1'b1;
            sdram_data = d;
            tick();
            sdram_dok = 1'b0;
        end
    endtask

    initial begin
        int n;
        cpu_cs   = 1'b1;
        cpu_addr = 17'h04000;
        tick();
        chk("rst_req", {31'd0, sdram_req}, 0);
        chk("rst_addr", {15'd0, sdram_addr}, 0);
        chk("rst_cpu_ok", {31'd0, cpu_ok}, 0);
        chk("rst_gfx_ok", {31'd0, gfx_ok}, 0);
        chk("rst_cpu_data", {24'd0, cpu_data}, 0);
        rstn = 1'b1;

        exp_q.push_back(17'h04000);
        serve(8'h5A, 2, 4, 1'b0, '0);
        chk("fill_data", {24'd0, cpu_data}, 8'h5A);
        chk("fill_ok", {31'd0, cpu_ok}, 1);
        chk("fill_gfx_ok", {31'd0, gfx_ok}, 0);

        repeat (5) tick();
        chk("hold_noreq", {31'd0, sdram_req}, 0);
        chk("hold_ok", {31'd0, cpu_ok}, 1);
        cpu_addr = 17'h04001;
        #1;
        chk("addr_chg_ok", {31'd0, cpu_ok}, 0);
        exp_q.push_back(17'h04001);
        serve(8'h66, 0, 0, 1'b0, '0);
        chk("same_cyc_data", {24'd0, cpu_data}, 8'h66);
        chk("same_cyc_ok", {31'd0, cpu_ok}, 1);
        tick();
        chk("same_cyc_idle", {31'd0, sdram_req}, 0);

        cpu_addr = 17'h04000;
        exp_q.push_back(17'h04000);
        serve(8'h11, 1, 3, 1'b1, 17'h08000);
        chk("mid_ok", {31'd0, cpu_ok}, 0);
        chk("mid_data", {24'd0, cpu_data}, 8'h11);
        cpu_addr = 17'h04000;
        #1;
        chk("mid_stored", {31'd0, cpu_ok}, 1);
        tick();
        chk("mid_noreq", {31'd0, sdram_req}, 0);
        cpu_addr = 17'h08000;
        exp_q.push_back(17'h08000);
        serve(8'h22, 0, 2, 1'b0, '0);
        chk("mid_next_data", {24'd0, cpu_data}, 8'h22);

        gfx_cs   = 1'b1;
        gfx_addr = 17'h10000;
        cpu_addr = 17'h00100;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 8; k++) begin
                exp_q.push_back(cpu_addr);
                serve(8'(8'h30 + k), 0, 2, 1'b0, '0);
                chk("starve_cpu_data", {24'd0, cpu_data}, 32'(8'h30 + k));
                chk("starve_gfx_wait", {31'd0, gfx_ok}, 0);
                cpu_addr = cpu_addr + 17'd1;
            end
            exp_q.push_back(gfx_addr);
            serve(8'(8'hA0 + r), 0, 2, 1'b0, '0);
            chk("starve_gfx_ok", {31'd0, gfx_ok}, 1);
            chk("starve_gfx_data", {24'd0, gfx_data}, 32'(8'hA0 + r));
            gfx_addr = gfx_addr + 17'd1;
        end

        cpu_addr = 17'h0C000;
        wait_req();
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_req", {31'd0, sdram_req}, 0);
        chk("arst_cpu_ok", {31'd0, cpu_ok}, 0);
        chk("arst_gfx_ok", {31'd0, gfx_ok}, 0);
        tick();
        rstn = 1'b1;
        exp_q.push_back(17'h0C000);
        serve(8'h77, 1, 2, 1'b0, '0);
        chk("arst_cpu_data", {24'd0, cpu_data}, 8'h77);
        exp_q.push_back(gfx_addr);
        serve(8'h88, 1, 2, 1'b0, '0);
        chk("arst_gfx_data", {24'd0, gfx_data}, 8'h88);
        chk("arst_gfx_ok2", {31'd0, gfx_ok}, 1);
        gfx_cs = 1'b0;
        #1;
        chk("gfx_cs_drop", {31'd0, gfx_ok}, 0);

`ifdef JTLABRUN_ROMARB_TIMEOUT_EN
        cpu_addr = 17'h0D000;
        wait_req();
        n = 0;
        while (sdram_req && n < 100) begin
            tick();
            n++;
        end
        chk("tmo_len", n, 64);
        n = 0;
        while (!sdram_req && n < 4) begin
            tick();
            n++;
        end
        chk("tmo_rearm", {31'd0, n <= 2}, 1);
        chk("tmo_addr", {15'd0, sdram_addr}, 17'h0D000);
`else
        n = 0;
`endif
        chk("queue_empty", exp_q.size() + n * 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
